// File: rtl/pilot_harmonic_axis.sv
// pilot_harmonic_axis: AXI-Stream Chebyshev harmonic generator for the 19 kHz pilot.
// Produces T2(x)=2x^2-1 (38 kHz) or T3(x)=4x^3-3x (57 kHz) through a 4-stage pipeline
// with full valid/ready backpressure and tlast passthrough.
// Optional macro PILOT_AGC_EN enables block-peak gain normalisation; when it is undefined
// gain_shift and peak_level are tied to zero and S1 only clips the most negative code.
module pilot_harmonic_axis #(
  parameter int DATA_W   = 32,
  parameter int HARMONIC = 2,
  parameter int WINDOW   = 4096
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_aresetn,
  input  logic                      s00_axis_tvalid,
  output logic                      s00_axis_tready,
  input  logic [DATA_W-1:0]         s00_axis_tdata,
  input  logic                      s00_axis_tlast,
  input  logic [DATA_W/8-1:0]       s00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  input  logic                      m00_axis_tready,
  output logic [DATA_W-1:0]         m00_axis_tdata,
  output logic                      m00_axis_tlast,
  output logic [DATA_W/8-1:0]       m00_axis_tstrb,
  output logic [$clog2(DATA_W)-1:0] gain_shift,
  output logic [DATA_W-2:0]         peak_level
);

  localparam int SW = $clog2(DATA_W);
  localparam int PW = 2 * DATA_W;
  localparam int RW = DATA_W + 3;

  localparam logic signed [DATA_W-1:0] MAX_D  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D  = -MAX_D;
  localparam logic signed [PW-1:0]     MAX_P  = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     MIN_P  = -MAX_P;
  localparam logic signed [RW-1:0]     MAX_R  = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0]     MIN_R  = -MAX_R;
  localparam logic signed [RW-1:0]     HALF_R = {3'b000, 1'b1, {(DATA_W-1){1'b0}}};

  if (HARMONIC != 2 && HARMONIC != 3) begin : g_bad_harmonic
    $error("pilot_harmonic_axis: HARMONIC must be 2 or 3");
  end
  if (WINDOW < 4 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("pilot_harmonic_axis: WINDOW must be a power of two >= 4");
  end

  logic adv;
  assign adv             = !m00_axis_tvalid || m00_axis_tready;
  assign s00_axis_tready = adv && s00_axis_aresetn;
  assign m00_axis_tstrb  = '1;

  // Stage registers
  logic                     v1, v2, v3;
  logic                     l1, l2, l3;
  logic signed [DATA_W-1:0] s1_x;
  logic signed [DATA_W-1:0] s2_x, s2_x2;
  logic signed [DATA_W-1:0] s3_x, s3_x2, s3_x3;

  // S1 input scaling with symmetric saturation
  logic signed [PW-1:0]     in_w, shl_w;
  logic signed [DATA_W-1:0] x_in;
  assign in_w = {{DATA_W{s00_axis_tdata[DATA_W-1]}}, s00_axis_tdata};

  // Shift by the current gain and clip to the symmetric range
  always_comb begin
    shl_w = in_w <<< gain_shift;
    if (shl_w > MAX_P)      x_in = MAX_D;
    else if (shl_w < MIN_P) x_in = MIN_D;
    else                    x_in = shl_w[DATA_W-1:0];
  end

  // S2/S3 products; taking bits [PW-2:DATA_W-1] is the truncating >>> (DATA_W-1)
  logic signed [PW-1:0]     p2, p3;
  logic signed [DATA_W-1:0] sq, cu;
  assign p2 = PW'(s1_x) * PW'(s1_x);
  assign sq = p2[PW-2:DATA_W-1];
  assign p3 = PW'(s2_x2) * PW'(s2_x);
  assign cu = p3[PW-2:DATA_W-1];

  // S4 harmonic combination in widened arithmetic, then saturate
  logic signed [RW-1:0]     r;
  logic signed [DATA_W-1:0] y;
  always_comb begin
    if (HARMONIC == 2) r = (RW'(s3_x2) <<< 1) - HALF_R;
    else               r = (RW'(s3_x3) <<< 2) - (RW'(s3_x) <<< 1) - RW'(s3_x);
    if (r > MAX_R)      y = MAX_D;
    else if (r < MIN_R) y = MIN_D;
    else                y = r[DATA_W-1:0];
  end

  // Pipeline advance: every stage moves together or holds together
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; l3 <= 1'b0;
      s1_x <= '0; s2_x <= '0; s2_x2 <= '0;
      s3_x <= '0; s3_x2 <= '0; s3_x3 <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else if (adv) begin
      v1    <= s00_axis_tvalid;
      l1    <= s00_axis_tlast;
      s1_x  <= x_in;
      v2    <= v1;
      l2    <= l1;
      s2_x  <= s1_x;
      s2_x2 <= sq;
      v3    <= v2;
      l3    <= l2;
      s3_x  <= s2_x;
      s3_x2 <= s2_x2;
      s3_x3 <= cu;
      m00_axis_tvalid <= v3;
      m00_axis_tlast  <= l3;
      m00_axis_tdata  <= y;
    end
  end

`ifdef PILOT_AGC_EN
  localparam int CW = $clog2(WINDOW);

  function automatic logic [SW-1:0] lzc(input logic [DATA_W-2:0] v);
    logic [SW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DATA_W - 1; i++) begin
      if (!found && v[DATA_W-2-i]) begin
        n     = SW'(i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic                accept;
  logic [DATA_W-1:0]   neg;
  logic [DATA_W-2:0]   mag, run_max, running;
  logic [CW-1:0]       win_cnt;
  logic                upd;

  assign accept = s00_axis_tvalid && s00_axis_tready;

  // Magnitude of the incoming sample, most negative code clipped to full scale
  always_comb begin
    neg = -s00_axis_tdata;
    if (!s00_axis_tdata[DATA_W-1]) mag = s00_axis_tdata[DATA_W-2:0];
    else if (neg[DATA_W-1])        mag = '1;
    else                           mag = neg[DATA_W-2:0];
    run_max = (mag > running) ? mag : running;
  end

  // Window peak tracker; gain is derived one cycle after the peak latches
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      running    <= '0;
      win_cnt    <= '0;
      upd        <= 1'b0;
      peak_level <= '0;
      gain_shift <= '0;
    end else begin
      upd <= 1'b0;
      if (accept) begin
        if (win_cnt == CW'(WINDOW - 1)) begin
          peak_level <= run_max;
          running    <= '0;
          win_cnt    <= '0;
          upd        <= 1'b1;
        end else begin
          running <= run_max;
          win_cnt <= win_cnt + CW'(1);
        end
      end
      if (upd) gain_shift <= lzc(peak_level);
    end
  end
`else
  assign gain_shift = '0;
  assign peak_level = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s00_axis_tstrb, p2[PW-1], p2[DATA_W-2:0], p3[PW-1], p3[DATA_W-2:0],
                       s3_x, s3_x2, s3_x3};

endmodule

// File: doc/pilot_harmonic_axis.md
Name: pilot_harmonic_axis

Overview:
- Parametrised successor to the fixed pilot tripler in the FM stereo/RDS receive chain.
- Takes band-passed 19 kHz pilot samples over AXI-Stream and produces the 2nd or 3rd Chebyshev harmonic (38 kHz or 57 kHz carrier) as T2(x)=2x²−1 or T3(x)=4x³−3x.
- Output feeds the downstream carrier band-pass filter, which removes residual fundamental.
- Adds full valid/ready backpressure, tlast propagation, and block-peak automatic gain normalisation so output amplitude does not depend on pilot level.

Parameters:
- DATA_W, 32: sample width on both streams; signed Q1.(DATA_W−1), value = int/2^(DATA_W−1).
- HARMONIC, 2: harmonic order; legal values 2 or 3; any other value is an elaboration error.
- WINDOW, 4096: accepted input beats per peak-measurement window; power of two, ≥4.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  synchronous active-low reset.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when tvalid&&tready.
- s00_axis_tdata  in  DATA_W  signed pilot sample.
- s00_axis_tlast  in  1  frame marker, passed through aligned with its sample.
- s00_axis_tstrb  in  DATA_W/8  ignored.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  DATA_W  signed harmonic sample, Q1.(DATA_W−1).
- m00_axis_tlast  out  1  delayed copy of input tlast.
- m00_axis_tstrb  out  DATA_W/8  constant all ones.
- gain_shift  out  $clog2(DATA_W)  current normalisation left-shift.
- peak_level  out  DATA_W−1  last latched window peak magnitude.

Behaviour:
- Reset (aresetn low at a clock edge):
  - Clears all stage valids, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, peak_level, gain_shift, running peak and window counter.
  - s00_axis_tready=0 combinationally while aresetn is low.
  - Reset mid-stream discards all in-flight beats.
- Pipeline: 4 register stages, all sharing advance enable adv = !m00_axis_tvalid || m00_axis_tready.
  - s00_axis_tready = adv && aresetn.
  - Latency 4 cycles from acceptance to m00_axis_tvalid when unstalled.
  - Bubbles propagate as invalid stages.
  - While stalled, all stages and m00 outputs hold.
  - No beat is dropped or duplicated; order is preserved.
- S1: x = sat(tdata <<< gain_shift).
  - Saturation clips to ±(2^(DATA_W−1)−1); the most negative code is also clipped to −(2^(DATA_W−1)−1).
- S2: x2 = (x*x) >>> (DATA_W−1), truncated.
- S3: x3 = (x2*x) >>> (DATA_W−1), truncated; x and x2 carried forward.
- S4: result computed in DATA_W+3 bits, saturated to ±(2^(DATA_W−1)−1), registered to m00_axis_tdata.
  - HARMONIC=2: 2·x2 − 2^(DATA_W−1).
  - HARMONIC=3: 4·x3 − 3·x.
- tlast travels with its sample through all stages.
- Peak tracker (accepted beats only):
  - a = |tdata|, clipped to 2^(DATA_W−1)−1.
  - running = max(running, a).
  - Counter counts 0..WINDOW−1.
  - On the beat where count==WINDOW−1: peak_level <= max(running, a); running <= 0; count <= 0.
  - Next cycle: gain_shift <= leading-zero count of peak_level within its DATA_W−1 bits. peak_level==0 gives gain_shift 0.
  - A new gain_shift applies to beats entering S1 after the update; in-flight beats keep their old shift.
  - Until the first window completes, gain_shift=0.

Optional Feature:
- PILOT_AGC_EN defined: peak tracker and shift normalisation as above.
- PILOT_AGC_EN undefined:
  - Tracker logic removed; gain_shift tied 0, peak_level tied 0.
  - S1 only applies the most-negative-code clip.

Test Plan:
1. Hold aresetn low 3 cycles with s00_axis_tvalid=1 and tdata=0x40000000 → s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tdata=0, gain_shift=0 throughout; first output 4 cycles after release.
2. HARMONIC=3, AGC off, m_tready=1, inputs 0x40000000, 0xC0000000, 0x00000000 → outputs 0x80000001, 0x7FFFFFFF, 0x00000000 at cycles 4, 5, 6 after the first acceptance.
3. HARMONIC=2, AGC off, inputs 0x40000000, 0x00000000, 0x7FFFFFFF → outputs 0xC0000000, 0x80000001, ≈0x7FFFFFFC (±4 LSB).
4. Six beats, tlast on beat 6, m_tready low cycles 3–9 → s00_axis_tready mirrors adv; outputs appear in order with values unchanged while stalled; tlast only on output 6; no loss or duplicates.
5. AGC on, WINDOW=16:
   - 16 beats of a sine with peak 0x08000000 → peak_level=0x08000000, gain_shift=3.
   - Next beat 0x08000000 produces the same output as an unshifted 0x40000000 input.
   - Next beat 0x20000000 saturates in S1 to 0x7FFFFFFF.
6. AGC on, WINDOW=16, 16 zero beats → peak_level=0, gain_shift=0; 19 kHz sine sampled at 240 kS/s through HARMONIC=3 gives a dominant 57 kHz output tone in an FFT check.
